// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] ENTRY_POINT_DEFAULT = 32'h0000_0028;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: interrupt entry beats redirect; also forms the sequential PC.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] ENTRY_POINT = ENTRY_POINT_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic            int_req,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            flush,
  output logic [XLEN-1:0] new_pc,
  output logic [XLEN-1:0] seq_pc
);

  logic [XLEN-1:0] target_aligned;

  // Redirect targets are byte addresses; fetch is always word aligned.
  assign target_aligned = redirect_target & ~(XLEN'(3));
  assign flush          = int_req | redirect_valid;
  assign new_pc         = int_req ? ENTRY_POINT : target_aligned;
  assign seq_pc         = pc + PC_STEP;

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, issues one imem request at a time, holds the word for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] ENTRY_POINT = ENTRY_POINT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            int_req,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_ins,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pcp4
);

  state_e          state, state_nx;
  logic [XLEN-1:0] pc, pc_nx;
  logic            kill, kill_nx;
  logic [XLEN-1:0] ins_q, pc_q;
  logic            load_out;
  logic            flush;
  logic            active;
  logic [XLEN-1:0] new_pc, seq_pc;

  fetch_next_pc #(.ENTRY_POINT(ENTRY_POINT)) u_next_pc (
    .pc             (pc),
    .int_req        (int_req),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .flush          (flush),
    .new_pc         (new_pc),
    .seq_pc         (seq_pc)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_nx = state;
    pc_nx    = pc;
    kill_nx  = kill;
    load_out = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nx = ST_FETCH;
        if (flush) pc_nx = new_pc;
      end
      ST_FETCH: begin
        if (flush) pc_nx = new_pc;
        else       state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          // A flush or an earlier kill makes this response stale.
          if (flush || kill) begin
            kill_nx  = 1'b0;
            state_nx = ST_FETCH;
            if (flush) pc_nx = new_pc;
          end else begin
            load_out = 1'b1;
            pc_nx    = seq_pc;
            state_nx = ST_HOLD;
          end
        end else if (flush) begin
          pc_nx   = new_pc;
          kill_nx = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          pc_nx    = new_pc;
          state_nx = ST_FETCH;
        end else if (id_ready) begin
          state_nx = ST_FETCH;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state <= ST_IDLE;
      pc    <= ENTRY_POINT;
      kill  <= 1'b0;
      ins_q <= '0;
      pc_q  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      kill  <= kill_nx;
      if (load_out) begin
        ins_q <= imem_rdata;
        pc_q  <= pc;
      end
    end
  end

  assign active    = (state != ST_IDLE);
  assign imem_req  = (state == ST_FETCH) && !flush;
  assign id_valid  = (state == ST_HOLD) && !flush;
  assign imem_addr = active ? pc : '0;
  assign id_ins    = active ? ins_q : '0;
  assign id_pc     = active ? pc_q : '0;
  assign id_pcp4   = active ? (pc_q + PC_STEP) : '0;

endmodule
